adc_capture_ctrl: RTL and testbench
===================================

ADC_CAPTURE_CTRL -- requirements
Module: adc_capture_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 8: capture buffer depth DEPTH = 2^ADDR_W words of 64 bits.
REQ-002 SHALL have parameter PRE_LEN, default 64: number of pre-trigger words; legal range 1..DEPTH-2.
REQ-003 SHALL have port i_125clk, input, 1 bit: sole clock. All logic is on the rising edge.
REQ-004 SHALL have port i_reset, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port i_data, input, 64 bits: packed ADC word.
REQ-006 SHALL have port i_data_valid, input, 1 bit: i_data is valid this cycle.
REQ-007 SHALL have port i_arm, input, 1 bit: start-capture pulse.
REQ-008 SHALL have port i_trig, input, 1 bit: trigger, sampled only together with i_data_valid.
REQ-009 SHALL have port i_abort, input, 1 bit: cancel the current operation.
REQ-010 SHALL have port i_rd_start, input, 1 bit: begin readout.
REQ-011 SHALL have port i_rd_ready, input, 1 bit: consumer accepts one word.
REQ-012 SHALL have ports o_wren (1 bit), o_wraddress (ADDR_W bits) and o_wrdata (64 bits), outputs: BRAM write port.
REQ-013 SHALL have port o_rdaddress, output, ADDR_W bits: BRAM read address.
REQ-014 SHALL have ports o_rd_valid and o_rd_last, outputs, 1 bit each: BRAM q is valid this cycle / is the final word.
REQ-015 SHALL have ports o_busy and o_done, outputs, 1 bit each: status flags.
REQ-016 SHALL have port o_trig_addr, output, ADDR_W bits: buffer address of the trigger word.

Function
REQ-017 SHALL implement states IDLE, PREFILL, WAIT_TRIG, POST, DONE and READ.
REQ-018 IDLE: i_arm=1 SHALL set the write pointer to 0 and the word counter to 0, then go to PREFILL.
REQ-019 In PREFILL, WAIT_TRIG and POST, each i_data_valid word SHALL be written at the write pointer: o_wren=1, o_wrdata=i_data and o_wraddress=pointer, all registered (1-cycle latency). The pointer then increments and wraps from DEPTH-1 to 0.
REQ-020 PREFILL: after PRE_LEN words have been written, the state SHALL go to WAIT_TRIG. i_trig is ignored in PREFILL.
REQ-021 WAIT_TRIG: a word with i_trig=1 SHALL be written, its address latched into o_trig_addr, and the state SHALL go to POST. Words without i_trig overwrite the ring indefinitely.
REQ-022 POST: the state SHALL go to DONE after the last of the DEPTH-PRE_LEN words counted from the trigger word (trigger word included) has been written.
REQ-023 DONE: o_done=1 and no writes. i_rd_start=1 SHALL load o_rdaddress = (o_trig_addr - PRE_LEN) mod DEPTH and go to READ.
REQ-024 READ: each cycle with i_rd_ready=1 SHALL advance o_rdaddress by 1 (wrapping). o_rd_valid SHALL be asserted exactly one cycle after each accepted address.
REQ-025 READ: exactly DEPTH addresses SHALL be issued. o_rd_last SHALL be asserted together with the final o_rd_valid, and the state then goes to IDLE.
REQ-026 o_busy SHALL be 1 in PREFILL, WAIT_TRIG, POST and READ, and 0 otherwise.
REQ-027 i_abort=1 in any state SHALL go to IDLE on the next edge. It also deasserts o_wren, o_rd_valid and o_rd_last on that edge. i_abort has priority over all other inputs.
REQ-028 i_arm outside IDLE and i_rd_start outside DONE SHALL be ignored.
REQ-029 Counters SHALL be ADDR_W+1 bits wide so that a count of DEPTH is representable. Pointer arithmetic SHALL be modulo DEPTH.

Reset
REQ-030 i_reset=1 SHALL force IDLE, both pointers to 0, the counter to 0, and every output to 0. i_reset has priority over i_abort.
REQ-031 Reset asserted mid-capture or mid-readout SHALL leave no pending write or valid strobe after the reset edge.

Configuration
REQ-032 With ADC_CAPTURE_AUTOREARM_EN defined, completion of READ SHALL go directly to PREFILL with the write pointer and counter cleared, as if i_arm had been pulsed.
REQ-033 Without ADC_CAPTURE_AUTOREARM_EN, completion of READ SHALL go to IDLE and a new i_arm is required.

Verification
REQ-034 Scenario: ADDR_W=8, PRE_LEN=64; arm; continuous valid words 0,1,2,...; i_trig on word 100 -> o_trig_addr=100; writes end after word 291; o_done=1.
REQ-035 Scenario: continue REQ-034; i_rd_start; i_rd_ready held high -> read addresses 36..255 then 0..35; 256 o_rd_valid pulses, each 1 cycle after its address; o_rd_last with the 256th; then IDLE.
REQ-036 Scenario: i_trig pulsed on words 10 and 40 (in PREFILL) -> no transition to POST; trigger on word 70 -> o_trig_addr=70.
REQ-037 Scenario: wrap during pre-trigger; trigger on word 300 -> o_trig_addr=44; readout starts at address 236.
REQ-038 Scenario: i_abort during POST, and separately i_reset during READ -> IDLE next cycle, o_wren/o_rd_valid/o_done=0; the following arm and capture succeed.
REQ-039 Scenario: i_rd_ready toggling 1,0,1,0 in READ -> the address advances only on ready cycles; the count of o_rd_valid pulses equals the count of ready cycles until 256.

Source files
------------

// File: rtl/adc_capture_ctrl.sv
// ADC capture controller: pre/post-trigger ring capture into a BRAM and
// ordered readout starting at the oldest pre-trigger word.
//
// Parameters:
//   ADDR_W  - buffer address width, DEPTH = 2**ADDR_W words of 64 bits
//   PRE_LEN - pre-trigger words kept ahead of the trigger (1..DEPTH-2)
// Ports:
//   i_125clk, i_reset      - clock, synchronous active-high reset
//   i_data, i_data_valid   - incoming ADC words
//   i_arm, i_trig, i_abort - capture control
//   i_rd_start, i_rd_ready - readout control
//   o_wren/o_wraddress/o_wrdata - BRAM write port (registered)
//   o_rdaddress            - BRAM read address
//   o_rd_valid, o_rd_last  - BRAM q valid / final word
//   o_busy, o_done         - status
//   o_trig_addr            - buffer address of the trigger word
// Build option: define ADC_CAPTURE_AUTOREARM_EN to restart capture
// immediately after a completed readout instead of returning to IDLE.

module adc_capture_ctrl #(
    parameter int ADDR_W  = 8,
    parameter int PRE_LEN = 64
) (
    input  logic              i_125clk,
    input  logic              i_reset,
    input  logic [63:0]       i_data,
    input  logic              i_data_valid,
    input  logic              i_arm,
    input  logic              i_trig,
    input  logic              i_abort,
    input  logic              i_rd_start,
    input  logic              i_rd_ready,
    output logic              o_wren,
    output logic [ADDR_W-1:0] o_wraddress,
    output logic [63:0]       o_wrdata,
    output logic [ADDR_W-1:0] o_rdaddress,
    output logic              o_rd_valid,
    output logic              o_rd_last,
    output logic              o_busy,
    output logic              o_done,
    output logic [ADDR_W-1:0] o_trig_addr
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam int CW    = ADDR_W + 1;

    localparam logic [CW-1:0]     C_ONE     = CW'(1);
    localparam logic [CW-1:0]     PRE_LAST  = CW'(PRE_LEN - 1);
    localparam logic [CW-1:0]     POST_LAST = CW'(DEPTH - PRE_LEN - 1);
    localparam logic [CW-1:0]     RD_LAST   = CW'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] A_ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] PRE_A     = ADDR_W'(PRE_LEN);

    typedef enum logic [2:0] {
        S_IDLE,
        S_PREFILL,
        S_WAIT_TRIG,
        S_POST,
        S_DONE,
        S_READ
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [ADDR_W-1:0] trig_q, trig_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [CW-1:0]     rd_cnt_q, rd_cnt_d;
    logic              wren_q, wren_d;
    logic [ADDR_W-1:0] wraddr_q, wraddr_d;
    logic [63:0]       wrdata_q, wrdata_d;
    logic              rd_valid_q, rd_valid_d;
    logic              rd_last_q, rd_last_d;
    logic              capturing;

    assign capturing = (state_q == S_PREFILL) ||
                       (state_q == S_WAIT_TRIG) ||
                       (state_q == S_POST);

    always_ff @(posedge i_125clk) begin
        if (i_reset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            cnt_q      <= '0;
            trig_q     <= '0;
            rd_addr_q  <= '0;
            rd_cnt_q   <= '0;
            wren_q     <= 1'b0;
            wraddr_q   <= '0;
            wrdata_q   <= '0;
            rd_valid_q <= 1'b0;
            rd_last_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            cnt_q      <= cnt_d;
            trig_q     <= trig_d;
            rd_addr_q  <= rd_addr_d;
            rd_cnt_q   <= rd_cnt_d;
            wren_q     <= wren_d;
            wraddr_q   <= wraddr_d;
            wrdata_q   <= wrdata_d;
            rd_valid_q <= rd_valid_d;
            rd_last_q  <= rd_last_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        cnt_d      = cnt_q;
        trig_d     = trig_q;
        rd_addr_d  = rd_addr_q;
        rd_cnt_d   = rd_cnt_q;
        wren_d     = 1'b0;
        wraddr_d   = wraddr_q;
        wrdata_d   = wrdata_q;
        rd_valid_d = 1'b0;
        rd_last_d  = 1'b0;

        if (i_abort) begin
            // Strobes already default to 0, so only the state moves.
            state_d = S_IDLE;
        end else begin
            if (capturing && i_data_valid) begin
                wren_d   = 1'b1;
                wraddr_d = wr_ptr_q;
                wrdata_d = i_data;
                wr_ptr_d = wr_ptr_q + A_ONE;
            end

            unique case (state_q)
                S_IDLE: begin
                    if (i_arm) begin
                        wr_ptr_d = '0;
                        cnt_d    = '0;
                        state_d  = S_PREFILL;
                    end
                end
                S_PREFILL: begin
                    if (i_data_valid) begin
                        cnt_d = cnt_q + C_ONE;
                        if (cnt_q == PRE_LAST) begin
                            state_d = S_WAIT_TRIG;
                        end
                    end
                end
                S_WAIT_TRIG: begin
                    // The trigger word itself is the first post word.
                    if (i_data_valid && i_trig) begin
                        trig_d  = wr_ptr_q;
                        cnt_d   = C_ONE;
                        state_d = S_POST;
                    end
                end
                S_POST: begin
                    if (i_data_valid) begin
                        cnt_d = cnt_q + C_ONE;
                        if (cnt_q == POST_LAST) begin
                            state_d = S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    if (i_rd_start) begin
                        // Oldest retained word sits PRE_LEN below the trigger.
                        rd_addr_d = trig_q - PRE_A;
                        rd_cnt_d  = '0;
                        state_d   = S_READ;
                    end
                end
                S_READ: begin
                    if (i_rd_ready) begin
                        rd_valid_d = 1'b1;
                        rd_addr_d  = rd_addr_q + A_ONE;
                        rd_cnt_d   = rd_cnt_q + C_ONE;
                        if (rd_cnt_q == RD_LAST) begin
                            rd_last_d = 1'b1;
`ifdef ADC_CAPTURE_AUTOREARM_EN
                            wr_ptr_d  = '0;
                            cnt_d     = '0;
                            state_d   = S_PREFILL;
`else
                            state_d   = S_IDLE;
`endif
                        end
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    assign o_wren      = wren_q;
    assign o_wraddress = wraddr_q;
    assign o_wrdata    = wrdata_q;
    assign o_rdaddress = rd_addr_q;
    assign o_rd_valid  = rd_valid_q;
    assign o_rd_last   = rd_last_q;
    assign o_trig_addr = trig_q;
    assign o_busy      = capturing || (state_q == S_READ);
    assign o_done      = (state_q == S_DONE);

endmodule

// File: tb/tb_adc_capture_ctrl.sv
// Directed bench for adc_capture_ctrl (ADDR_W=8, PRE_LEN=64).
// Expected addresses and counts are hand-derived per scenario.

module tb_adc_capture_ctrl;

    localparam int AW    = 8;
    localparam int DEPTH = 256;
    localparam int PRE   = 64;
    localparam int POSTN = DEPTH - PRE;

    logic          clk = 1'b0;
    logic          rst;
    logic [63:0]   data;
    logic          dval;
    logic          arm;
    logic          trig;
    logic          abort_s;
    logic          rd_start;
    logic          rd_ready;
    logic          wren;
    logic [AW-1:0] wraddr;
    logic [63:0]   wrdata;
    logic [AW-1:0] rdaddr;
    logic          rd_valid;
    logic          rd_last;
    logic          busy;
    logic          done;
    logic [AW-1:0] trig_addr;

    int nvec = 0;
    int nmis = 0;

    always #4 clk = ~clk;

    adc_capture_ctrl #(.ADDR_W(AW), .PRE_LEN(PRE)) dut (
        .i_125clk    (clk),
        .i_reset     (rst),
        .i_data      (data),
        .i_data_valid(dval),
        .i_arm       (arm),
        .i_trig      (trig),
        .i_abort     (abort_s),
        .i_rd_start  (rd_start),
        .i_rd_ready  (rd_ready),
        .o_wren      (wren),
        .o_wraddress (wraddr),
        .o_wrdata    (wrdata),
        .o_rdaddress (rdaddr),
        .o_rd_valid  (rd_valid),
        .o_rd_last   (rd_last),
        .o_busy      (busy),
        .o_done      (done),
        .o_trig_addr (trig_addr)
    );

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge; outputs are then sampled 1ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_arm();
        arm = 1'b1;
        step();
        arm = 1'b0;
        check("arm_busy", busy, 1);
    endtask

    task automatic capture_full(input int tw, input int ig0, input int ig1,
                                input int exp_ta);
        int errs;
        errs = 0;
        do_arm();
        for (int w = 0; w <= tw + POSTN - 1; w++) begin
            dval = 1'b1;
            data = 64'(w);
            trig = (w == tw) || (w == ig0) || (w == ig1);
            step();
            if (wren !== 1'b1 || wraddr !== AW'(w % DEPTH) ||
                wrdata !== 64'(w)) errs++;
            if (w < tw + POSTN - 1 && done !== 1'b0) errs++;
        end
        trig = 1'b0;
        check("wr_stream", errs, 0);
        check("trig_addr", trig_addr, exp_ta);
        check("done", done, 1);
        check("busy_done", busy, 0);
        data = 64'hdead;
        step();
        check("no_wr_done", wren, 0);
        dval = 1'b0;
    endtask

    task automatic readout(input int start_a, input bit toggle);
        int errs;
        int nval;
        int nlast;
        int expa;
        int cyc;
        logic rdy;
        logic [AW-1:0] pa;
        errs  = 0;
        nval  = 0;
        nlast = 0;
        cyc   = 0;
        expa  = start_a;
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("rd_start_addr", rdaddr, start_a);
        check("rd_busy", busy, 1);
        while (nval < DEPTH && cyc < 2000) begin
            rdy = toggle ? ((cyc % 2) == 0) : 1'b1;
            rd_ready = rdy;
            pa = rdaddr;
            if (rdy && pa !== AW'(expa)) errs++;
            step();
            cyc++;
            if (rd_valid !== rdy) errs++;
            if (rdy) begin
                expa = (expa + 1) % DEPTH;
                nval++;
            end
            if (rd_last === 1'b1) nlast++;
            if (rdy && (rd_last !== (nval == DEPTH))) errs++;
            if (!rdy && rd_last !== 1'b0) errs++;
        end
        rd_ready = 1'b0;
        check("rd_seq", errs, 0);
        check("rd_count", nval, DEPTH);
        check("rd_last_cnt", nlast, 1);
        check("rd_idle", busy, 0);
        step();
        check("rd_valid_off", rd_valid, 0);
    endtask

    initial begin
        rst      = 1'b1;
        data     = '0;
        dval     = 1'b0;
        arm      = 1'b0;
        trig     = 1'b0;
        abort_s  = 1'b0;
        rd_start = 1'b0;
        rd_ready = 1'b0;
        step();
        step();
        check("rst_wren", wren, 0);
        check("rst_rdv", rd_valid, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_rdaddr", rdaddr, 0);
        check("rst_trig", trig_addr, 0);
        rst = 1'b0;

        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        check("ign_rdstart", busy, 0);

        capture_full(100, -1, -1, 100);
        readout(36, 1'b0);

        capture_full(70, 10, 40, 70);
        readout(6, 1'b1);

        capture_full(300, -1, -1, 44);
        readout(236, 1'b0);

        // Abort while in POST.
        do_arm();
        for (int w = 0; w < 70; w++) begin
            dval = 1'b1;
            data = 64'(w);
            trig = (w == 64);
            step();
        end
        trig = 1'b0;
        check("pre_abort_ta", trig_addr, 64);
        abort_s = 1'b1;
        step();
        abort_s = 1'b0;
        dval = 1'b0;
        check("abort_wren", wren, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);

        capture_full(100, -1, -1, 100);

        // Reset in the middle of a readout.
        rd_start = 1'b1;
        step();
        rd_start = 1'b0;
        rd_ready = 1'b1;
        for (int c = 0; c < 5; c++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        rd_ready = 1'b0;
        check("rst_rd_valid", rd_valid, 0);
        check("rst_rd_busy", busy, 0);
        check("rst_rd_addr", rdaddr, 0);
        check("rst_rd_done", done, 0);

        capture_full(120, -1, -1, 120);
        readout(56, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
